// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller: digit rotation, frame-aligned
// page switching, anode blanking and a blinking decimal point on digit 2.
module fnd_scan_ctrl #(
    parameter int unsigned P_SCAN_DIV  = 100_000,
    parameter int unsigned P_BLINK_DIV = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_page,
    input  logic       i_blank_en,
    input  logic       i_dp_en,
    output logic [2:0] o_sel,
    output logic [3:0] o_an,
    output logic       o_dp,
    output logic       o_scan_tick
);

    localparam int unsigned SCAN_W  = (P_SCAN_DIV  > 1) ? $clog2(P_SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (P_BLINK_DIV > 1) ? $clog2(P_BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(P_SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(P_BLINK_DIV - 1);

    logic [SCAN_W-1:0]  pre_q,   pre_d;
    logic [1:0]         digit_q, digit_d;
    logic               page_q,  page_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               phase_q, phase_d;
    logic               blank_q, blank_d;
    logic               tick_c;
    logic               blink_last_c;

    // Next-state logic; the page only changes on the edge closing digit 3.
    always_comb begin
        tick_c       = (pre_q == SCAN_LAST);
        blink_last_c = (blink_q == BLINK_LAST);
        pre_d        = tick_c ? '0 : pre_q + SCAN_W'(1);
        digit_d      = tick_c ? digit_q + 2'd1 : digit_q;
        page_d       = (tick_c && (digit_q == 2'd3)) ? i_page : page_q;
        blink_d      = blink_last_c ? '0 : blink_q + BLINK_W'(1);
        phase_d      = blink_last_c ? ~phase_q : phase_q;
        blank_d      = i_blank_en;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pre_q   <= '0;
            digit_q <= 2'd0;
            page_q  <= 1'b0;
            blink_q <= '0;
            phase_q <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            digit_q <= digit_d;
            page_q  <= page_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

    // Outputs decode straight from the registers; i_dp_en gates the point combinationally.
    assign o_sel       = {page_q, digit_q};
    assign o_an        = blank_q ? 4'b1111 : ~(4'b0001 << digit_q);
    assign o_dp        = ~(i_dp_en & phase_q & (digit_q == 2'd2) & ~blank_q);
    assign o_scan_tick = tick_c;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl with P_SCAN_DIV=4, P_BLINK_DIV=8.
module tb_fnd_scan_ctrl;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] an;
        logic       dp;
        logic       tick;
    } exp_t;

    logic       i_clk;
    logic       i_reset;
    logic       i_page;
    logic       i_blank_en;
    logic       i_dp_en;
    logic [2:0] o_sel;
    logic [3:0] o_an;
    logic       o_dp;
    logic       o_scan_tick;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: cycles since the last reset edge, page and blank registers.
    int   n;
    logic page_m;
    logic blank_m;

    fnd_scan_ctrl #(.P_SCAN_DIV(4), .P_BLINK_DIV(8)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_page      (i_page),
        .i_blank_en  (i_blank_en),
        .i_dp_en     (i_dp_en),
        .o_sel       (o_sel),
        .o_an        (o_an),
        .o_dp        (o_dp),
        .o_scan_tick (o_scan_tick)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Drive one cycle of inputs, predict the post-edge outputs, push, then advance.
    task automatic drive(input logic rst, input logic pg, input logic blk, input logic dp);
        exp_t e;
        int   dig;
        i_reset    = rst;
        i_page     = pg;
        i_blank_en = blk;
        i_dp_en    = dp;
        if (rst) begin
            n       = 0;
            page_m  = 1'b0;
            blank_m = 1'b0;
        end else begin
            if (n % 16 == 15) page_m = pg;
            n       = n + 1;
            blank_m = blk;
        end
        dig   = (n / 4) % 4;
        e.sel = {page_m, 2'(dig)};
        case (dig)
            0:       e.an = 4'b1110;
            1:       e.an = 4'b1101;
            2:       e.an = 4'b1011;
            default: e.an = 4'b0111;
        endcase
        if (blank_m) e.an = 4'b1111;
        e.dp   = (dp && ((n / 8) % 2 == 1) && (dig == 2) && !blank_m) ? 1'b0 : 1'b1;
        e.tick = (n % 4 == 3);
        sb.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, got;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1);
            e   = sb.pop_front();
            got = {o_sel, o_an, o_dp, o_scan_tick};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset k=%0d actual=%b required=%b", k, got, e);
            end
        end
        n_checks++;
        if ({o_sel, o_an, o_dp, o_scan_tick} !== 9'b000_1110_1_0) begin
            n_fail++;
            $display("FAIL reset_const actual=%b required=000111010", {o_sel, o_an, o_dp, o_scan_tick});
        end
    endtask

    task automatic test_free_run();
        exp_t e, got;
        int   ticks = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            e   = sb.pop_front();
            got = {o_sel, o_an, o_dp, o_scan_tick};
            if (o_scan_tick === 1'b1) ticks++;
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL free_run n=%0d actual=%b required=%b", n, got, e);
            end
            if (k == 3) begin
                n_checks++;
                if (o_scan_tick !== 1'b1) begin
                    n_fail++;
                    $display("FAIL first_tick actual=%b required=1", o_scan_tick);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (o_an !== 4'b1101) begin
                    n_fail++;
                    $display("FAIL an_after_tick actual=%b required=1101", o_an);
                end
            end
        end
        n_checks++;
        if (ticks != 5) begin
            n_fail++;
            $display("FAIL tick_count actual=%0d required=5", ticks);
        end
    endtask

    task automatic test_page();
        exp_t e, got;
        logic pg;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int k = 1; k <= 36; k++) begin
            pg = ((k >= 5) && (k <= 8)) || ((k >= 13) && (k <= 31));
            drive(1'b0, pg, 1'b0, 1'b0);
            e   = sb.pop_front();
            got = {o_sel, o_an, o_dp, o_scan_tick};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL page n=%0d actual=%b required=%b", n, got, e);
            end
            if (k == 15 || k == 32) begin
                n_checks++;
                if (o_sel[2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL page_hold n=%0d actual=%b required=0", n, o_sel[2]);
                end
            end
            if (k == 16) begin
                n_checks++;
                if (o_sel !== 3'b100) begin
                    n_fail++;
                    $display("FAIL page_switch actual=%b required=100", o_sel);
                end
            end
        end
    endtask

    task automatic test_dp();
        exp_t e, got;
        int   lows = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int k = 1; k <= 39; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            e   = sb.pop_front();
            got = {o_sel, o_an, o_dp, o_scan_tick};
            if (o_dp === 1'b0) lows++;
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL dp n=%0d actual=%b required=%b", n, got, e);
            end
        end
        n_checks++;
        if (lows != 8) begin
            n_fail++;
            $display("FAIL dp_low_count actual=%0d required=8", lows);
        end
    endtask

    task automatic test_blank();
        exp_t e, got;
        int   blanked = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, (k >= 7) && (k <= 12), 1'b1);
            e   = sb.pop_front();
            got = {o_sel, o_an, o_dp, o_scan_tick};
            if (o_an === 4'b1111) blanked++;
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL blank n=%0d actual=%b required=%b", n, got, e);
            end
        end
        n_checks++;
        if (blanked != 6) begin
            n_fail++;
            $display("FAIL blank_count actual=%0d required=6", blanked);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int k = 1; k <= 28; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            e   = sb.pop_front();
            got = {o_sel, o_an, o_dp, o_scan_tick};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL pre_reset n=%0d actual=%b required=%b", n, got, e);
            end
        end
        n_checks++;
        if (o_sel !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_reset_sel actual=%b required=111", o_sel);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        e   = sb.pop_front();
        got = {o_sel, o_an, o_dp, o_scan_tick};
        n_checks++;
        if (got !== 9'b000_1110_1_0 || got !== e) begin
            n_fail++;
            $display("FAIL mid_reset actual=%b required=%b", got, e);
        end
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            e   = sb.pop_front();
            got = {o_sel, o_an, o_dp, o_scan_tick};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL restart n=%0d actual=%b required=%b", n, got, e);
            end
        end
    endtask

    initial begin
        i_reset    = 1'b1;
        i_page     = 1'b0;
        i_blank_en = 1'b0;
        i_dp_en    = 1'b0;
        n          = 0;
        page_m     = 1'b0;
        blank_m    = 1'b0;
        test_reset();
        test_free_run();
        test_page();
        test_dp();
        test_blank();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
